// File: rtl/simmem_release_scheduler_if.sv
// Request/bank/release bus between the release scheduler and its neighbours.
// The scheduler takes the slave modport; upstream and the message bank together form the master side.
interface simmem_release_scheduler_if #(
  parameter int TotalCapacity = 128,
  parameter int IDWidth       = 4,
  parameter int DelayWidth    = 8
);
  localparam int AddrWidth = $clog2(TotalCapacity);
  localparam int CntWidth  = $clog2(TotalCapacity + 1);

  logic                     req_valid_i;
  logic                     req_ready_o;
  logic [IDWidth-1:0]       req_id_i;
  logic [DelayWidth-1:0]    req_delay_i;
  logic                     rsv_ready_o;
  logic                     rsv_valid_i;
  logic [IDWidth-1:0]       rsv_id_o;
  logic [AddrWidth-1:0]     rsv_addr_i;
  logic [TotalCapacity-1:0] release_en_o;
  logic                     released_valid_i;
  logic [AddrWidth-1:0]     released_addr_i;
  logic [CntWidth-1:0]      outstanding_o;
  logic                     err_o;

  modport master (
    output req_valid_i, req_id_i, req_delay_i, rsv_valid_i, rsv_addr_i,
           released_valid_i, released_addr_i,
    input  req_ready_o, rsv_ready_o, rsv_id_o, release_en_o, outstanding_o, err_o
  );

  modport slave (
    input  req_valid_i, req_id_i, req_delay_i, rsv_valid_i, rsv_addr_i,
           released_valid_i, released_addr_i,
    output req_ready_o, rsv_ready_o, rsv_id_o, release_en_o, outstanding_o, err_o
  );
endinterface

// File: rtl/simmem_release_scheduler.sv
// Reserves message-bank slots, counts each slot's delay down and flags it releasable;
// a slot returns to FREE when the bank reports the message left it.
module simmem_release_scheduler #(
  parameter int TotalCapacity = 128,
  parameter int IDWidth       = 4,
  parameter int DelayWidth    = 8
) (
  input logic                       clk_i,
  input logic                       rst_i,
  simmem_release_scheduler_if.slave bus
);
  localparam int AddrWidth = $clog2(TotalCapacity);
  localparam int CntWidth  = $clog2(TotalCapacity + 1);

  typedef enum logic [1:0] {
    SLOT_FREE       = 2'd0,
    SLOT_COUNTING   = 2'd1,
    SLOT_RELEASABLE = 2'd2
  } slot_state_e;

  slot_state_e              state_r [TotalCapacity];
  logic [DelayWidth-1:0]    cnt_r   [TotalCapacity];
  logic [TotalCapacity-1:0] release_en_r;
  logic [CntWidth-1:0]      outstanding_r;
  logic                     err_r;

  logic rh_s;
  logic rel_legal_s;
  logic rel_illegal_s;
  logic same_slot_s;
  logic rsv_conflict_s;
  logic occupy_s;

  assign bus.rsv_ready_o   = bus.req_valid_i;
  assign bus.req_ready_o   = bus.rsv_valid_i;
  assign bus.rsv_id_o      = bus.req_id_i;
  assign bus.release_en_o  = release_en_r;
  assign bus.outstanding_o = outstanding_r;
  assign bus.err_o         = err_r;

  assign rh_s          = bus.req_valid_i && bus.rsv_valid_i;
  assign rel_legal_s   = bus.released_valid_i && (state_r[bus.released_addr_i] == SLOT_RELEASABLE);
  assign rel_illegal_s = bus.released_valid_i && !rel_legal_s;
  assign same_slot_s   = rel_legal_s && (bus.released_addr_i == bus.rsv_addr_i);
  // A reservation onto a slot freed in the same cycle is legal: release applies first.
  assign rsv_conflict_s = rh_s && (state_r[bus.rsv_addr_i] != SLOT_FREE) && !same_slot_s;
  assign occupy_s       = rh_s && !rsv_conflict_s;

  // Per-slot state machines, registered release enables, occupancy count and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < TotalCapacity; i++) begin
        state_r[i] <= SLOT_FREE;
        cnt_r[i]   <= '0;
      end
      release_en_r  <= '0;
      outstanding_r <= '0;
      err_r         <= 1'b0;
    end else begin
      for (int i = 0; i < TotalCapacity; i++) begin
        if (rh_s && (bus.rsv_addr_i == AddrWidth'(i))) begin
          if (bus.req_delay_i <= DelayWidth'(1)) begin
            state_r[i] <= SLOT_RELEASABLE;
            cnt_r[i]   <= '0;
          end else begin
            state_r[i] <= SLOT_COUNTING;
            cnt_r[i]   <= bus.req_delay_i - DelayWidth'(1);
          end
        end else if (rel_legal_s && (bus.released_addr_i == AddrWidth'(i))) begin
          state_r[i] <= SLOT_FREE;
          cnt_r[i]   <= '0;
        end else if (state_r[i] == SLOT_COUNTING) begin
          if (cnt_r[i] <= DelayWidth'(1)) begin
            state_r[i] <= SLOT_RELEASABLE;
            cnt_r[i]   <= '0;
          end else begin
            cnt_r[i] <= cnt_r[i] - DelayWidth'(1);
          end
        end
        // Mask the slot being released so the bank never sees a stale enable.
        release_en_r[i] <= (state_r[i] == SLOT_RELEASABLE) &&
                           !(rel_legal_s && (bus.released_addr_i == AddrWidth'(i)));
      end

      if (occupy_s && !rel_legal_s) begin
        outstanding_r <= outstanding_r + CntWidth'(1);
      end else if (rel_legal_s && !occupy_s) begin
        outstanding_r <= outstanding_r - CntWidth'(1);
      end

      if (rsv_conflict_s || rel_illegal_s) begin
        err_r <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Scoreboard bench: each reservation pushes its expected release cycle; entries pop into the
// expected enable vector when due, and scenario tasks compare DUT outputs against it.
module tb_simmem_release_scheduler;
  localparam int TC = 128;
  localparam int IW = 4;
  localparam int DW = 8;

  typedef struct {
    int slot;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  simmem_release_scheduler_if #(.TotalCapacity(TC), .IDWidth(IW), .DelayWidth(DW)) bus ();

  simmem_release_scheduler #(.TotalCapacity(TC), .IDWidth(IW), .DelayWidth(DW)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  exp_t          sb_q[$];
  logic [TC-1:0] exp_rel;
  bit            busy[TC];
  int            exp_out;
  bit            exp_err;
  int            cyc;
  int            errors;
  int            checks;

  task automatic set_idle();
    bus.req_valid_i      = 1'b0;
    bus.rsv_valid_i      = 1'b0;
    bus.req_id_i         = '0;
    bus.req_delay_i      = '0;
    bus.rsv_addr_i       = '0;
    bus.released_valid_i = 1'b0;
    bus.released_addr_i  = '0;
  endtask

  task automatic drive_rsv(input int slot, input int d, input int id);
    bus.req_valid_i = 1'b1;
    bus.rsv_valid_i = 1'b1;
    bus.rsv_addr_i  = 7'(slot);
    bus.req_delay_i = 8'(d);
    bus.req_id_i    = 4'(id);
  endtask

  task automatic drive_rel(input int slot);
    bus.released_valid_i = 1'b1;
    bus.released_addr_i  = 7'(slot);
  endtask

  // Advance one clock and update the reference model with what was driven at that edge.
  task automatic step();
    bit do_rst;
    bit rh;
    bit rl;
    int ra;
    int rla;
    int d;
    do_rst = rst;
    rh     = bus.req_valid_i && bus.rsv_valid_i;
    ra     = int'(bus.rsv_addr_i);
    d      = int'(bus.req_delay_i);
    rl     = bus.released_valid_i;
    rla    = int'(bus.released_addr_i);
    @(posedge clk);
    #1;
    cyc++;
    if (do_rst) begin
      exp_rel = '0;
      foreach (busy[i]) busy[i] = 1'b0;
      exp_out = 0;
      exp_err = 1'b0;
      sb_q.delete();
    end else begin
      if (rl) begin
        if (exp_rel[rla]) begin
          exp_rel[rla] = 1'b0;
          busy[rla]    = 1'b0;
          exp_out--;
        end else begin
          exp_err = 1'b1;
        end
      end
      if (rh) begin
        if (busy[ra]) exp_err = 1'b1;
        else exp_out++;
        busy[ra]    = 1'b1;
        exp_rel[ra] = 1'b0;
        for (int i = sb_q.size() - 1; i >= 0; i--) if (sb_q[i].slot == ra) sb_q.delete(i);
        sb_q.push_back('{ra, cyc + ((d <= 1) ? 1 : d)});
      end
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
        if (sb_q[i].due == cyc) begin
          exp_rel[sb_q[i].slot] = 1'b1;
          sb_q.delete(i);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    step();
    step();
    rst = 1'b0;
    checks++;
    if (bus.release_en_o !== '0) begin errors++; $display("FAIL reset_release_en: got %h expected 0", bus.release_en_o); end
    checks++;
    if (bus.outstanding_o !== 8'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", bus.outstanding_o); end
    checks++;
    if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", bus.err_o); end
    checks++;
    if (bus.rsv_ready_o !== 1'b0) begin errors++; $display("FAIL reset_rsv_ready: got %0b expected 0", bus.rsv_ready_o); end
  endtask

  task automatic test_basic_delay();
    drive_rsv(5, 3, 10);
    #1;
    checks++;
    if (bus.rsv_ready_o !== 1'b1) begin errors++; $display("FAIL pass_rsv_ready: got %0b expected 1", bus.rsv_ready_o); end
    checks++;
    if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL pass_req_ready: got %0b expected 1", bus.req_ready_o); end
    checks++;
    if (bus.rsv_id_o !== 4'd10) begin errors++; $display("FAIL pass_rsv_id: got %0d expected 10", bus.rsv_id_o); end
    step();
    set_idle();
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (bus.release_en_o[5] !== (k >= 3)) begin
        errors++; $display("FAIL basic_bit5_t%0d: got %0b expected %0b", k, bus.release_en_o[5], (k >= 3));
      end
      checks++;
      if (bus.release_en_o !== exp_rel) begin errors++; $display("FAIL basic_vec: got %h expected %h", bus.release_en_o, exp_rel); end
    end
    checks++;
    if (bus.outstanding_o !== 8'd1) begin errors++; $display("FAIL basic_outstanding: got %0d expected 1", bus.outstanding_o); end
    drive_rel(5);
    step();
    set_idle();
    checks++;
    if (bus.release_en_o[5] !== 1'b0) begin errors++; $display("FAIL basic_release: got %0b expected 0", bus.release_en_o[5]); end
    checks++;
    if (int'(bus.outstanding_o) !== exp_out) begin errors++; $display("FAIL basic_out_after: got %0d expected %0d", bus.outstanding_o, exp_out); end
  endtask

  task automatic test_short_delay();
    for (int d = 0; d <= 1; d++) begin
      drive_rsv(0, d, d);
      step();
      set_idle();
      checks++;
      if (bus.release_en_o[0] !== 1'b0) begin errors++; $display("FAIL short_d%0d_early: got %0b expected 0", d, bus.release_en_o[0]); end
      step();
      checks++;
      if (bus.release_en_o[0] !== 1'b1) begin errors++; $display("FAIL short_d%0d_on: got %0b expected 1", d, bus.release_en_o[0]); end
      drive_rel(0);
      step();
      set_idle();
      checks++;
      if (bus.release_en_o[0] !== 1'b0) begin errors++; $display("FAIL short_d%0d_clear: got %0b expected 0", d, bus.release_en_o[0]); end
      checks++;
      if (bus.outstanding_o !== 8'd0) begin errors++; $display("FAIL short_d%0d_out: got %0d expected 0", d, bus.outstanding_o); end
    end
  endtask

  task automatic test_fill();
    int budget;
    for (int s = 0; s < TC; s++) begin
      drive_rsv(s, 255, s);
      step();
      checks++;
      if (bus.release_en_o !== exp_rel) begin errors++; $display("FAIL fill_vec: got %h expected %h", bus.release_en_o, exp_rel); end
    end
    set_idle();
    checks++;
    if (bus.outstanding_o !== 8'd128) begin errors++; $display("FAIL fill_outstanding: got %0d expected 128", bus.outstanding_o); end
    bus.req_valid_i = 1'b1;
    #1;
    checks++;
    if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL fill_req_ready_low: got %0b expected 0", bus.req_ready_o); end
    set_idle();
    budget = 400;
    while (sb_q.size() > 0 && budget > 0) begin
      step();
      budget--;
      checks++;
      if (bus.release_en_o !== exp_rel) begin errors++; $display("FAIL fill_count_vec: got %h expected %h", bus.release_en_o, exp_rel); end
    end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL fill_timeout: got %0d pending expected 0", sb_q.size()); end
    checks++;
    if (bus.release_en_o !== {TC{1'b1}}) begin errors++; $display("FAIL fill_all_on: got %h expected all ones", bus.release_en_o); end
    for (int s = 0; s < TC; s++) begin
      drive_rel(s);
      step();
      checks++;
      if (bus.release_en_o !== exp_rel) begin errors++; $display("FAIL fill_drain_vec: got %h expected %h", bus.release_en_o, exp_rel); end
    end
    set_idle();
    checks++;
    if (bus.outstanding_o !== 8'd0) begin errors++; $display("FAIL fill_drained: got %0d expected 0", bus.outstanding_o); end
  endtask

  task automatic test_release_reload();
    drive_rsv(7, 1, 3);
    step();
    set_idle();
    step();
    checks++;
    if (bus.release_en_o[7] !== 1'b1) begin errors++; $display("FAIL reload_setup: got %0b expected 1", bus.release_en_o[7]); end
    drive_rel(7);
    drive_rsv(7, 4, 3);
    step();
    set_idle();
    checks++;
    if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reload_err: got %0b expected 0", bus.err_o); end
    checks++;
    if (bus.outstanding_o !== 8'd1) begin errors++; $display("FAIL reload_out: got %0d expected 1", bus.outstanding_o); end
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) step();
      checks++;
      if (bus.release_en_o[7] !== (k == 4)) begin
        errors++; $display("FAIL reload_bit7_t%0d: got %0b expected %0b", k, bus.release_en_o[7], (k == 4));
      end
    end
    drive_rel(7);
    step();
    set_idle();
    checks++;
    if (int'(bus.outstanding_o) !== exp_out) begin errors++; $display("FAIL reload_drain: got %0d expected %0d", bus.outstanding_o, exp_out); end
  endtask

  task automatic test_early_release();
    int t0;
    drive_rsv(9, 5, 1);
    step();
    set_idle();
    t0 = cyc;
    step();
    drive_rel(9);
    step();
    set_idle();
    checks++;
    if (bus.err_o !== 1'b1) begin errors++; $display("FAIL early_err: got %0b expected 1", bus.err_o); end
    checks++;
    if (bus.outstanding_o !== 8'd1) begin errors++; $display("FAIL early_out: got %0d expected 1", bus.outstanding_o); end
    while (cyc < t0 + 6) begin
      step();
      checks++;
      if (bus.release_en_o[9] !== (cyc >= t0 + 5)) begin
        errors++; $display("FAIL early_bit9_c%0d: got %0b expected %0b", cyc - t0, bus.release_en_o[9], (cyc >= t0 + 5));
      end
    end
    drive_rel(9);
    step();
    set_idle();
    checks++;
    if (bus.outstanding_o !== 8'd0) begin errors++; $display("FAIL early_drain: got %0d expected 0", bus.outstanding_o); end
    checks++;
    if (bus.err_o !== exp_err) begin errors++; $display("FAIL early_sticky: got %0b expected %0b", bus.err_o, exp_err); end
  endtask

  task automatic test_mid_reset();
    for (int s = 20; s < 30; s++) begin
      drive_rsv(s, 30 + s, s);
      step();
    end
    set_idle();
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (bus.outstanding_o !== 8'd10) begin errors++; $display("FAIL midrst_pre: got %0d expected 10", bus.outstanding_o); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.release_en_o !== '0) begin errors++; $display("FAIL midrst_release_en: got %h expected 0", bus.release_en_o); end
    checks++;
    if (bus.outstanding_o !== 8'd0) begin errors++; $display("FAIL midrst_outstanding: got %0d expected 0", bus.outstanding_o); end
    checks++;
    if (bus.err_o !== 1'b0) begin errors++; $display("FAIL midrst_err: got %0b expected 0", bus.err_o); end
    for (int k = 0; k < 100; k++) begin
      step();
      checks++;
      if (bus.release_en_o !== '0) begin errors++; $display("FAIL midrst_late_release: got %h expected 0", bus.release_en_o); end
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    cyc     = 0;
    exp_rel = '0;
    exp_out = 0;
    exp_err = 1'b0;
    rst     = 1'b1;
    set_idle();
    test_reset();
    test_basic_delay();
    test_short_delay();
    test_fill();
    test_release_reload();
    test_early_release();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
